lfo_ctrl_decoder: RTL and testbench

- Upstream control stage for the LFO block.
- Parses a byte stream from the host serial receiver into LFO register writes.
- Drives the LFO's shared 16-bit amplitude/frequency data bus, the one-cycle frequency/amplitude load strobes, and the held 2-bit wave-type register.
- Protocol: one address byte followed by two data bytes (MSB first), with inter-byte timeout and error reporting.

---
 rtl/lfo_ctrl_pkg.sv | 53 +++++
 rtl/lfo_ctrl_timeout.sv | 51 +++++
 rtl/lfo_ctrl_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_lfo_ctrl_decoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lfo_ctrl_pkg
// Shared types and constants for the LFO control decoder.
//   - ctrl_state_e : decoder FSM states (CHECK exists only when
//                    LFO_CTRL_CHECKSUM_EN is defined)
//   - ADDR_*       : register address map of the host protocol
//   - wave_type_e  : LFO wave select, shared with the LFO itself
//   - is_legal_addr / frame_checksum : protocol helper functions
// Optional build macro: LFO_CTRL_CHECKSUM_EN (adds a 4th XOR checksum byte).
// -----------------------------------------------------------------------------
package lfo_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DATA_HI = 3'd1,
    ST_DATA_LO = 3'd2,
    ST_COMMIT  = 3'd3
`ifdef LFO_CTRL_CHECKSUM_EN
    ,
    ST_CHECK   = 3'd4
`endif
  } ctrl_state_e;

  localparam logic [7:0] ADDR_FREQ = 8'h01;
  localparam logic [7:0] ADDR_AMP  = 8'h02;
  localparam logic [7:0] ADDR_WAVE = 8'h03;
  localparam logic [7:0] ADDR_BOTH = 8'h04;

  typedef enum logic [1:0] {
    SINE     = 2'd0,
    SQUARE   = 2'd1,
    TRIANGLE = 2'd2,
    SAW      = 2'd3
  } wave_type_e;

  // True for the four addresses the decoder accepts.
  function automatic logic is_legal_addr(input logic [7:0] addr);
    logic legal;
    case (addr)
      ADDR_FREQ, ADDR_AMP, ADDR_WAVE, ADDR_BOTH: legal = 1'b1;
      default:                                   legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Frame checksum byte: XOR of address, data MSB and data LSB.
  function automatic logic [7:0] frame_checksum(input logic [7:0] addr,
                                                input logic [7:0] msb,
                                                input logic [7:0] lsb);
    return addr ^ msb ^ lsb;
  endfunction

endpackage

// File: rtl/lfo_ctrl_timeout.sv
// -----------------------------------------------------------------------------
// lfo_ctrl_timeout
// Inter-byte idle counter for the LFO control decoder.
// Ports:
//   i_clock    : system clock
//   i_reset    : synchronous active-high reset (counter -> 0)
//   i_clear    : clear counter (has priority over i_enable)
//   i_enable   : count one per clock while high
//   o_terminal : high while enabled and count == TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module lfo_ctrl_timeout #(
  parameter int TIMEOUT_CYCLES = 25000000,
  parameter int CNT_WIDTH      = 25
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [CNT_WIDTH-1:0] TERMINAL_COUNT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE        = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Next count: clear wins over increment so an accepted byte always restarts.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_terminal = i_enable && (cnt_q == TERMINAL_COUNT);

endmodule

// File: rtl/lfo_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// lfo_ctrl_decoder
// Parses the host byte stream (address, data MSB, data LSB[, checksum]) into
// LFO register writes.
// Ports:
//   i_clock              : system clock (25 MHz)
//   i_reset              : synchronous active-high reset
//   i_rx_byte[7:0]       : received byte, valid with i_rx_valid
//   i_rx_valid           : one-cycle strobe per received byte
//   o_amplitude_freq_reg : write data to the LFO, held between writes
//   o_freq_en            : one-cycle frequency load strobe
//   o_amp_en             : one-cycle amplitude load strobe
//   o_wave_type_reg[1:0] : held wave select
//   o_busy               : a frame is in progress
//   o_err                : one-cycle pulse on bad address, timeout or checksum
// Optional build macro: LFO_CTRL_CHECKSUM_EN (4-byte frames with XOR check).
// All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module lfo_ctrl_decoder
  import lfo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 25000000,
  parameter int CNT_WIDTH      = 25
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [7:0]            i_rx_byte,
  input  logic                  i_rx_valid,
  output logic [DATA_WIDTH-1:0] o_amplitude_freq_reg,
  output logic                  o_freq_en,
  output logic                  o_amp_en,
  output logic [1:0]            o_wave_type_reg,
  output logic                  o_busy,
  output logic                  o_err
);

  ctrl_state_e           state_q, state_d;
  logic [7:0]            addr_q, addr_d;
  logic [7:0]            msb_q, msb_d;
  logic [7:0]            lsb_q, lsb_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  wave_type_e            wave_q, wave_d;
  logic                  freq_en_q, freq_en_d;
  logic                  amp_en_q, amp_en_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic                  accept_s;
  logic                  waiting_s;
  logic                  timeout_s;

  // The counter only runs while a frame is waiting for its next byte.
`ifdef LFO_CTRL_CHECKSUM_EN
  assign waiting_s = (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO) ||
                     (state_q == ST_CHECK);
`else
  assign waiting_s = (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO);
`endif

  lfo_ctrl_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_timeout (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (accept_s || !waiting_s),
    .i_enable   (waiting_s),
    .o_terminal (timeout_s)
  );

  // Next-state and output decode; a valid byte always takes priority over
  // the timeout terminal count.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    msb_d     = msb_q;
    lsb_d     = lsb_q;
    data_d    = data_q;
    wave_d    = wave_q;
    freq_en_d = 1'b0;
    amp_en_d  = 1'b0;
    err_d     = 1'b0;
    accept_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          if (is_legal_addr(i_rx_byte)) begin
            addr_d   = i_rx_byte;
            accept_s = 1'b1;
            state_d  = ST_DATA_HI;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DATA_HI: begin
        if (i_rx_valid) begin
          msb_d    = i_rx_byte;
          accept_s = 1'b1;
          state_d  = ST_DATA_LO;
        end else if (timeout_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA_HI;
        end
      end

      ST_DATA_LO: begin
        if (i_rx_valid) begin
          lsb_d    = i_rx_byte;
          accept_s = 1'b1;
`ifdef LFO_CTRL_CHECKSUM_EN
          state_d  = ST_CHECK;
`else
          state_d  = ST_COMMIT;
`endif
        end else if (timeout_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA_LO;
        end
      end

`ifdef LFO_CTRL_CHECKSUM_EN
      ST_CHECK: begin
        if (i_rx_valid) begin
          accept_s = 1'b1;
          if (i_rx_byte == frame_checksum(addr_q, msb_q, lsb_q)) begin
            state_d = ST_COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (timeout_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CHECK;
        end
      end
`endif

      ST_COMMIT: begin
        // Data and strobe land on the same edge; bytes arriving here are dropped.
        state_d = ST_IDLE;
        case (addr_q)
          ADDR_FREQ: begin
            data_d    = {msb_q, lsb_q};
            freq_en_d = 1'b1;
          end
          ADDR_AMP: begin
            data_d   = {msb_q, lsb_q};
            amp_en_d = 1'b1;
          end
          ADDR_BOTH: begin
            data_d    = {msb_q, lsb_q};
            freq_en_d = 1'b1;
            amp_en_d  = 1'b1;
          end
          ADDR_WAVE: begin
            wave_d = wave_type_e'(lsb_q[1:0]);
          end
          default: begin
            data_d = data_q;
          end
        endcase
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= 8'h00;
      msb_q     <= 8'h00;
      lsb_q     <= 8'h00;
      data_q    <= '0;
      wave_q    <= SINE;
      freq_en_q <= 1'b0;
      amp_en_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      msb_q     <= msb_d;
      lsb_q     <= lsb_d;
      data_q    <= data_d;
      wave_q    <= wave_d;
      freq_en_q <= freq_en_d;
      amp_en_q  <= amp_en_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign o_amplitude_freq_reg = data_q;
  assign o_freq_en            = freq_en_q;
  assign o_amp_en             = amp_en_q;
  assign o_wave_type_reg      = wave_q;
  assign o_busy               = busy_q;
  assign o_err                = err_q;

endmodule

// File: tb/tb_lfo_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// tb_lfo_ctrl_decoder
// Directed-vector bench for lfo_ctrl_decoder with TIMEOUT_CYCLES = 100.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_lfo_ctrl_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [15:0] data_out;
  logic        freq_en;
  logic        amp_en;
  logic [1:0]  wave_out;
  logic        busy;
  logic        err;

  int vec_cnt     = 0;
  int miscompares = 0;

  int freq_pulses = 0;
  int amp_pulses  = 0;
  int err_pulses  = 0;
  int dbl_pulses  = 0;
  logic freq_prev = 1'b0;
  logic amp_prev  = 1'b0;

  int base_freq;
  int base_amp;
  int base_err;
  int wait_cycles;

  lfo_ctrl_decoder #(
    .DATA_WIDTH     (16),
    .TIMEOUT_CYCLES (100),
    .CNT_WIDTH      (25)
  ) dut (
    .i_clock              (clk),
    .i_reset              (rst),
    .i_rx_byte            (rx_byte),
    .i_rx_valid           (rx_valid),
    .o_amplitude_freq_reg (data_out),
    .o_freq_en            (freq_en),
    .o_amp_en             (amp_en),
    .o_wave_type_reg      (wave_out),
    .o_busy               (busy),
    .o_err                (err)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping on the falling edge, away from the sampling point.
  always @(negedge clk) begin
    if (freq_en) freq_pulses = freq_pulses + 1;
    if (amp_en)  amp_pulses  = amp_pulses + 1;
    if (err)     err_pulses  = err_pulses + 1;
    if ((freq_en && freq_prev) || (amp_en && amp_prev)) dbl_pulses = dbl_pulses + 1;
    freq_prev = freq_en;
    amp_prev  = amp_en;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt = vec_cnt + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Byte is held valid across exactly one rising edge; returns 1 ns after it.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l);
    send_byte(a);
    idle(2);
    send_byte(h);
    idle(2);
    send_byte(l);
`ifdef LFO_CTRL_CHECKSUM_EN
    idle(2);
    send_byte(a ^ h ^ l);
`endif
  endtask

  // Called right after the last byte's edge: strobes are due one edge later
  // and must be gone the edge after that.
  task automatic strobe_check(input string tag, input logic exp_f, input logic exp_a,
                              input logic [15:0] exp_data, input logic [1:0] exp_wave);
    @(posedge clk);
    #1;
    check_vec({tag, "_freq_en"}, {31'd0, freq_en}, {31'd0, exp_f});
    check_vec({tag, "_amp_en"},  {31'd0, amp_en},  {31'd0, exp_a});
    check_vec({tag, "_data"},    {16'd0, data_out}, {16'd0, exp_data});
    check_vec({tag, "_wave"},    {30'd0, wave_out}, {30'd0, exp_wave});
    @(posedge clk);
    #1;
    check_vec({tag, "_strobe_off"}, {30'd0, freq_en, amp_en}, 32'd0);
    check_vec({tag, "_busy_off"},   {31'd0, busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_vec({tag, "_data"},  {16'd0, data_out}, 32'd0);
    check_vec({tag, "_wave"},  {30'd0, wave_out}, 32'd0);
    check_vec({tag, "_flags"}, {28'd0, freq_en, amp_en, busy, err}, 32'd0);
  endtask

  task automatic mark;
    base_freq = freq_pulses;
    base_amp  = amp_pulses;
    base_err  = err_pulses;
  endtask

  initial begin
    rst      = 1'b1;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    idle(3);
    check_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // Frequency write 0x0002.
    mark();
    send_byte(8'h01);
    check_vec("busy_in_frame", {31'd0, busy}, 32'd1);
    idle(2);
    send_byte(8'h00);
    idle(2);
    send_byte(8'h02);
`ifdef LFO_CTRL_CHECKSUM_EN
    idle(2);
    send_byte(8'h03);
`endif
    strobe_check("f1", 1'b1, 1'b0, 16'h0002, 2'd0);
    check_vec("f1_freq_count", freq_pulses - base_freq, 32'd1);
    check_vec("f1_amp_count",  amp_pulses - base_amp,   32'd0);
    idle(2);

    // Amplitude write 0x00FF, then wave-type write with no strobe.
    send_frame(8'h02, 8'h00, 8'hFF);
    strobe_check("amp", 1'b0, 1'b1, 16'h00FF, 2'd0);
    idle(2);
    mark();
    send_frame(8'h03, 8'h00, 8'h02);
    strobe_check("wave", 1'b0, 1'b0, 16'h00FF, 2'd2);
    check_vec("wave_no_strobe", (freq_pulses - base_freq) + (amp_pulses - base_amp), 32'd0);
    idle(2);

    // Combined write: both strobes on the same cycle.
    send_frame(8'h04, 8'h12, 8'h34);
    strobe_check("both", 1'b1, 1'b1, 16'h1234, 2'd2);
    idle(2);

    // Illegal address: single error pulse, never busy, no data consumed.
    mark();
    send_byte(8'h07);
    check_vec("badaddr_err",  {31'd0, err},  32'd1);
    check_vec("badaddr_busy", {31'd0, busy}, 32'd0);
    idle(1);
    check_vec("badaddr_err_off", {31'd0, err}, 32'd0);
    check_vec("badaddr_err_count", err_pulses - base_err, 32'd1);
    idle(2);
    send_frame(8'h01, 8'h00, 8'h05);
    strobe_check("after_bad", 1'b1, 1'b0, 16'h0005, 2'd2);
    idle(2);

    // Timeout after the MSB: error exactly 100 cycles after the last accepted byte.
    mark();
    send_byte(8'h01);
    idle(2);
    send_byte(8'h12);
    check_vec("tmo_busy", {31'd0, busy}, 32'd1);
    wait_cycles = 0;
    for (int i = 1; i <= 150; i++) begin
      @(posedge clk);
      #1;
      if (err) begin
        wait_cycles = i;
        break;
      end
    end
    check_vec("tmo_latency", wait_cycles, 32'd100);
    check_vec("tmo_busy_fall", {31'd0, busy}, 32'd0);
    idle(1);
    check_vec("tmo_err_off", {31'd0, err}, 32'd0);
    check_vec("tmo_no_strobe", (freq_pulses - base_freq) + (amp_pulses - base_amp), 32'd0);
    check_vec("tmo_data_held", {16'd0, data_out}, 32'h0005);
    check_vec("tmo_wave_held", {30'd0, wave_out}, 32'd2);
    idle(2);

    // Reset in the middle of a frame.
    mark();
    send_byte(8'h02);
    idle(2);
    send_byte(8'hAB);
    rst = 1'b1;
    idle(2);
    check_all_zero("midreset");
    rst = 1'b0;
    idle(10);
    check_vec("midreset_no_strobe", (freq_pulses - base_freq) + (amp_pulses - base_amp), 32'd0);
    check_all_zero("midreset_after");
    send_frame(8'h02, 8'h00, 8'h01);
    strobe_check("post_reset", 1'b0, 1'b1, 16'h0001, 2'd0);
    idle(2);

`ifdef LFO_CTRL_CHECKSUM_EN
    // Checksum mismatch: error, nothing written.
    mark();
    send_byte(8'h01);
    idle(2);
    send_byte(8'h00);
    idle(2);
    send_byte(8'h02);
    idle(2);
    send_byte(8'h00);
    check_vec("cks_bad_err", {31'd0, err}, 32'd1);
    idle(5);
    check_vec("cks_bad_no_strobe", (freq_pulses - base_freq) + (amp_pulses - base_amp), 32'd0);
    check_vec("cks_bad_data", {16'd0, data_out}, 32'h0001);
    check_vec("cks_bad_busy", {31'd0, busy}, 32'd0);
`endif

    check_vec("no_double_strobe", dbl_pulses, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
